// File: rtl/vector_unloader_pkg.sv
// Shared definitions for the vector unloader: default geometry, the
// element-index width helper and the control state enumeration.
package vector_unloader_pkg;

   localparam int DEF_REG_WIDTH  = 256;
   localparam int DEF_ELEM_WIDTH = 32;
   localparam int DEF_NUM_ELEM   = 8;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_CNT_WIDTH  = 8;

   // Index width for n elements; never narrower than one bit.
   function automatic int elem_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ELEM_IDX_WIDTH = elem_idx_width(DEF_NUM_ELEM);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/vector_unloader_if.sv
// Command, data-memory read port and output stream of the vector unloader.
// master: the unloader itself; slave: the host / memory / sink side.
interface vector_unloader_if
   import vector_unloader_pkg::*;
#(
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [CNT_WIDTH-1:0]  vec_count;
   logic                  busy;
   logic                  done;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [REG_WIDTH-1:0]  mem_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [ELEM_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      input  start, base_addr, vec_count, mem_rdata, out_ready,
      output busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, vec_count, mem_rdata, out_ready,
      input  busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
   );
endinterface

// File: rtl/vector_serializer.sv
// Holds one vector word and streams it out element 0 first under
// valid/ready. A load strobe (re)starts the sequence at element 0.
module vector_serializer
   import vector_unloader_pkg::*;
#(
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
   parameter int NUM_ELEM   = DEF_NUM_ELEM,
   parameter int IDX_WIDTH  = ELEM_IDX_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [REG_WIDTH-1:0]  load_data,
   output logic                  valid,
   input  logic                  ready,
   output logic [ELEM_WIDTH-1:0] data,
   output logic                  last
);
   logic [REG_WIDTH-1:0]  word_reg;
   logic [IDX_WIDTH-1:0]  idx_reg;
   logic                  valid_reg;
   logic [ELEM_WIDTH-1:0] elems [NUM_ELEM];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
         assign elems[gi] = word_reg[gi*ELEM_WIDTH +: ELEM_WIDTH];
      end
   endgenerate

   assign valid = valid_reg;
   assign last  = valid_reg && (idx_reg == IDX_WIDTH'(NUM_ELEM - 1));
   // Idle output is held at zero so nothing stale is visible between vectors.
   assign data  = valid_reg ? elems[idx_reg] : '0;

   // Capture a word on load, then step one element per accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_reg  <= '0;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         word_reg  <= load_data;
         idx_reg   <= '0;
         valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
         if (last) begin
            idx_reg   <= '0;
            valid_reg <= 1'b0;
         end else begin
            idx_reg <= idx_reg + IDX_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/vector_unloader.sv
// Readback engine: on start, reads vec_count consecutive vector words from
// data memory and streams them out as elements. Only one vector is ever in
// flight: the next read is issued only after the previous one is drained.
module vector_unloader
   import vector_unloader_pkg::*;
#(
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
   parameter int NUM_ELEM   = DEF_NUM_ELEM,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   vector_unloader_if.master bus
);
   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] base_reg;
   logic [CNT_WIDTH-1:0]  count_reg;
   logic [CNT_WIDTH-1:0]  vec_idx_reg;

   logic                  busy, done, mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  ser_load, ser_valid, ser_last, vec_drained;
   logic [ELEM_WIDTH-1:0] ser_data;
   logic                  last_vec;

   // count_reg is nonzero whenever vectors are being moved.
   assign last_vec    = (vec_idx_reg == count_reg - CNT_WIDTH'(1));
   assign vec_drained = ser_valid && bus.out_ready && ser_last;
   assign ser_load    = (state_reg == WAIT);

   vector_serializer #(
      .REG_WIDTH  (REG_WIDTH),
      .ELEM_WIDTH (ELEM_WIDTH),
      .NUM_ELEM   (NUM_ELEM),
      .IDX_WIDTH  (elem_idx_width(NUM_ELEM))
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .load_data (bus.mem_rdata),
      .valid     (ser_valid),
      .ready     (bus.out_ready),
      .data      (ser_data),
      .last      (ser_last)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Command parameters are latched only in IDLE, so a start while busy
   // cannot disturb them; vec_idx advances as each vector drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_reg    <= '0;
         count_reg   <= '0;
         vec_idx_reg <= '0;
      end else if (state_reg == IDLE && bus.start) begin
         base_reg    <= bus.base_addr;
         count_reg   <= bus.vec_count;
         vec_idx_reg <= '0;
      end else if (state_reg == SEND && vec_drained) begin
         vec_idx_reg <= vec_idx_reg + CNT_WIDTH'(1);
      end
   end

   // Next-state and control outputs.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      done       = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (bus.start) state_next = (bus.vec_count == '0) ? FIN : REQ;
         end
         REQ: begin
            mem_rd_en  = 1'b1;
            mem_addr   = base_reg + ADDR_WIDTH'(vec_idx_reg);
            state_next = WAIT;
         end
         WAIT: state_next = SEND;
         SEND: if (vec_drained) state_next = last_vec ? FIN : REQ;
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.mem_rd_en = mem_rd_en;
   assign bus.mem_addr  = mem_addr;
   assign bus.out_valid = ser_valid;
   assign bus.out_data  = ser_data;
   assign bus.out_last  = ser_last && last_vec;

endmodule

// File: tb/tb_vector_unloader.sv
// Directed bench for vector_unloader: a memory responder, a queue-based
// model of the expected reads and beats, and a per-cycle compare process.
module tb_vector_unloader;
   import vector_unloader_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vector_unloader_if bus ();

   vector_unloader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          done_count = 0;
   int          done_rel = -1;
   int          first_rd_rel = -1;
   int          first_valid_rel = -1;
   int          ready_mode = 0;
   bit          in_cmd = 1'b0;
   beat_t       exp_beats[$];
   logic [31:0] exp_reads[$];
   logic [31:0] got[$];
   logic [31:0] rd_log[$];
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic        prev_last = 1'b0;
   logic [31:0] prev_data = '0;

   // Memory contents: address 0x10 holds elements 1..8, every other word
   // holds {addr[27:0], element index}.
   function automatic logic [255:0] mem_word(input logic [31:0] a);
      logic [255:0] w;
      for (int e = 0; e < 8; e++)
         w[e*32 +: 32] = (a == 32'h10) ? 32'(e + 1) : {a[27:0], 4'(e)};
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=none", name, act);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Registered read: data appears the cycle after mem_rd_en.
   initial begin
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         bus.mem_rdata <= bus.mem_rd_en ? mem_word(bus.mem_addr) : {8{32'hDEAD_BEEF}};
      end
   end

   // Downstream ready: held high or pseudo-random, changed just after each edge.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Compare process: checks every output against the model mid-cycle.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         chk("busy", bus.busy, in_cmd && (cyc > start_cyc));
         if (bus.mem_rd_en) begin
            rd_log.push_back(bus.mem_addr);
            if (first_rd_rel < 0) first_rd_rel = cyc - start_cyc;
            if (exp_reads.size() == 0) fail_now("read_extra", bus.mem_addr);
            else chk("read_addr", bus.mem_addr, exp_reads.pop_front());
         end
         if (prev_valid && !prev_ready) begin
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_data", bus.out_data, prev_data);
            chk("stall_last", bus.out_last, prev_last);
         end
         if (bus.out_valid) begin
            if (first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
            if (exp_beats.size() == 0) begin
               fail_now("beat_extra", bus.out_data);
            end else begin
               chk("beat_data", bus.out_data, exp_beats[0].data);
               chk("beat_last", bus.out_last, exp_beats[0].last);
               if (bus.out_ready) begin
                  void'(exp_beats.pop_front());
                  got.push_back(bus.out_data);
               end
            end
         end else begin
            chk("last_without_valid", bus.out_last, 1'b0);
         end
         if (bus.done) begin
            done_count++;
            done_rel = cyc - start_cyc;
         end
         prev_valid = bus.out_valid;
         prev_ready = bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end
   end

   // Queue the expected reads/beats for a command and pulse start.
   task automatic start_cmd(input logic [31:0] base, input logic [7:0] count);
      logic [31:0]  a;
      logic [255:0] w;
      @(posedge clk);
      #1;
      for (int v = 0; v < int'(count); v++) begin
         a = base + 32'(v);
         w = mem_word(a);
         exp_reads.push_back(a);
         for (int e = 0; e < 8; e++)
            exp_beats.push_back('{data: w[e*32 +: 32], last: (v == int'(count) - 1) && (e == 7)});
      end
      got.delete();
      rd_log.delete();
      done_count      = 0;
      done_rel        = -1;
      first_rd_rel    = -1;
      first_valid_rel = -1;
      start_cyc       = cyc;
      in_cmd          = 1'b1;
      bus.start       = 1'b1;
      bus.base_addr   = base;
      bus.vec_count   = count;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [7:0] count);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.vec_count = count;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n = 0;
      while (done_count == 0 && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done_count == 0) fail_now({tag, "_done_timeout"}, 64'(n));
      in_cmd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_pulses"}, done_count, 1);
      chk({tag, "_beats_left"}, exp_beats.size(), 0);
      chk({tag, "_reads_left"}, exp_reads.size(), 0);
      exp_beats.delete();
      exp_reads.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 1'b0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_out_last"}, bus.out_last, 1'b0);
   endtask

   task automatic single_vector(input string tag);
      start_cmd(32'h10, 8'd1);
      wait_done(tag, 40);
      chk({tag, "_rd_cycle"}, first_rd_rel, 1);
      chk({tag, "_rd_addr"}, rd_log.size() > 0 ? rd_log[0] : 32'hFFFF_FFFF, 32'h10);
      chk({tag, "_valid_cycle"}, first_valid_rel, 3);
      chk({tag, "_done_cycle"}, done_rel, 11);
      chk({tag, "_nbeats"}, got.size(), 8);
      chk({tag, "_beat1"}, got.size() > 0 ? got[0] : 32'hFFFF_FFFF, 32'h1);
      chk({tag, "_beat8"}, got.size() > 7 ? got[7] : 32'hFFFF_FFFF, 32'h8);
   endtask

   initial begin
      int n;
      int dc;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.vec_count = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Single vector with exact latency.
      single_vector("single");

      // Three vectors; a start aimed at 0x99 mid-command must be ignored.
      start_cmd(32'h20, 8'd3);
      repeat (5) @(posedge clk);
      pulse_start(32'h99, 8'd5);
      wait_done("multi", 200);
      chk("multi_nbeats", got.size(), 24);
      chk("multi_beat9", got.size() > 8 ? got[8] : 32'hFFFF_FFFF, 32'h210);
      chk("multi_beat24", got.size() > 23 ? got[23] : 32'hFFFF_FFFF, 32'h227);
      chk("multi_nreads", rd_log.size(), 3);
      chk("multi_read3", rd_log.size() > 2 ? rd_log[2] : 32'hFFFF_FFFF, 32'h22);
      chk("multi_done_cycle", done_rel, 31);

      // Two vectors under random backpressure.
      ready_mode = 1;
      start_cmd(32'h30, 8'd2);
      wait_done("bp", 600);
      ready_mode = 0;
      chk("bp_nbeats", got.size(), 16);
      chk("bp_beat16", got.size() > 15 ? got[15] : 32'hFFFF_FFFF, 32'h317);

      // Zero count goes straight to FIN: done the cycle after start.
      start_cmd(32'h50, 8'd0);
      wait_done("zero", 20);
      chk("zero_done_cycle", done_rel, 1);
      chk("zero_nreads", rd_log.size(), 0);
      chk("zero_valid_seen", first_valid_rel, -1);

      // Address wrap at the top of the address space.
      start_cmd(32'hFFFF_FFFF, 8'd2);
      wait_done("wrap", 100);
      chk("wrap_read1", rd_log.size() > 0 ? rd_log[0] : 32'h1234, 32'hFFFF_FFFF);
      chk("wrap_read2", rd_log.size() > 1 ? rd_log[1] : 32'h1234, 32'h0);
      chk("wrap_beat2", got.size() > 1 ? got[1] : 32'h1234, 32'hFFFF_FFF1);
      chk("wrap_beat9", got.size() > 8 ? got[8] : 32'h1234, 32'h0);

      // Asynchronous reset while beat 4 of the first vector is presented.
      start_cmd(32'h40, 8'd2);
      n = 0;
      while (got.size() < 3 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rst_reached_beat4", got.size(), 3);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_mid");
      in_cmd = 1'b0;
      exp_beats.delete();
      exp_reads.delete();
      dc = done_count;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_done", done_count, dc);

      // After the abandoned command, a fresh start behaves as before.
      single_vector("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
